tile_scheduler: RTL
===================

# tile_scheduler

Multi-tile sequencer and accumulator for the systolic-array accelerator. It drives the existing datapath strobes to run a configurable grid of weight tiles: N output tiles, each reduced over K input-channel tiles. It accumulates the datapath's per-tile partial sums into wide signed sums and streams finished rows out over a valid/ready port. While the current tile streams, it prefetches the next tile's weights into the shadow weight buffer.

## Interface
Parameters:
- COLS, sys_cols: number of psum lanes.
- P_BW, P_BITWIDTH: datapath psum lane width (signed).
- ACC_BW, ACC_BITWIDTH (32): accumulator lane width; must be ≥ P_BW.
- ROWS, 16: psum vectors per tile.
- MAX_K, 16: maximum K tiles.
- MAX_N, 64: maximum N tiles.

Ports (KW = $clog2(MAX_K+1), NW = $clog2(MAX_N+1)):
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- cfg_k_tiles  in  KW  K tiles per output tile; latched on start.
- cfg_n_tiles  in  NW  output tiles; latched on start.
- ready  out  1  high iff in IDLE.
- cfg_err  out  1  sticky; set when start arrives with a zero cfg; cleared by the next accepted start.
- seq_err  out  1  sticky; set on a psum beyond ROWS in a tile; cleared by the next accepted start.
- w_read, if_read  out  1  datapath buffer-read enables.
- clr_w, clr_if  out  1  one-cycle address-clear pulses.
- switch  out  1  one-cycle weight shadow/active swap.
- w_done, if_done  in  1  one-cycle completion pulses from the datapath.
- psum_valid  in  1  psum_data is valid this cycle.
- psum_data  in  [COLS][P_BW]  signed partial-sum row.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  [COLS][ACC_BW]  accumulated row.
- out_last  out  1  marks the final row of the final N tile.

## Operation
- Tile order: n is the outer loop, k the inner loop.
- The psum row counter resets at each tile start.
- States and transitions:
  - IDLE: on start with nonzero cfg, latch cfg and go to LOAD_W. On start with a zero cfg, set cfg_err and stay in IDLE.
  - LOAD_W: pulse clr_w on entry. Hold w_read until w_done, then go to SWITCH.
  - SWITCH: pulse switch for one cycle, then go to STREAM.
  - STREAM: pulse clr_if on entry. Hold if_read until if_done, then go to DRAIN. If another tile remains, set pf_active on entry and also pulse clr_w on entry.
  - DRAIN: wait until row_cnt == ROWS and pf_active == 0. Then:
    - if k is not the last K tile: k++, go to SWITCH;
    - if k is the last K tile: go to FLUSH.
  - FLUSH: emit rows 0..ROWS-1. When done:
    - if n is not the last N tile: n++, k=0, go to SWITCH;
    - if n is the last N tile: go to IDLE.
- w_read = (state==LOAD_W) | pf_active. pf_active clears on w_done.
- Accumulation, on each psum_valid in STREAM or DRAIN with row_cnt < ROWS:
  - k==0: acc[row] = sign-extend(psum);
  - k>0: acc[row] += sign-extend(psum), per lane, wrapping modulo 2^ACC_BW.
- A psum_valid with row_cnt == ROWS is dropped and sets seq_err.
- A psum_valid in any other state is ignored.
- FLUSH output rules:
  - out_data = acc[row].
  - Once asserted, out_valid holds with stable data until out_ready; the transfer happens when out_valid & out_ready.
  - out_last is asserted with row ROWS-1 of the last N tile.
- start outside IDLE is ignored.
- rst from any state: return to IDLE, clear counters, pf_active and the sticky flags.

## Timing
- Reset values:
  - ready = 1.
  - All other outputs = 0.
  - Accumulator contents are don't-care.
- Strobe outputs are Moore, registered on state entry. w_read and if_read are combinational from state/pf_active.
- start accepted at cycle t:
  - LOAD_W at t+1, with w_read=1 and clr_w=1 at t+1.
  - w_done at cycle u gives w_read=0 and switch=1 at u+1.
- If w_done and if_done arrive in the same cycle, both are honoured.
- FLUSH sustains one row per cycle under constant out_ready. First out_valid is the cycle after DRAIN exits.
- Minimum wait from the last FLUSH handshake to ready=1: one cycle.

## Structure
- Config gains ACC_BITWIDTH and typedef enum sched_state_t {IDLE, LOAD_W, SWITCH, STREAM, DRAIN, FLUSH}.
- Sub-module psum_acc_buffer holds ROWS×COLS×ACC_BW storage:
  - write port with a first/accumulate select;
  - registered read port for FLUSH.
- tile_scheduler contains the FSM, counters, pf_active and the output handshake. It sits between controller-level start and the datapath, replacing controller in top.

## Test plan
- K=1, N=1, ROWS=4; psums rows {1,-2,3,-4} in all lanes → 4 outputs with those values, out_last on the 4th; ready returns; one switch pulse.
- K=3, N=1; each tile sends row value 5 → every output = 15. w_read is seen during STREAM of tiles 0 and 1 but not 2. Three switch pulses.
- K=2, N=2; out_ready toggling 1,0,0,1 → out_data stable while stalled; 8 rows total, out_last only on the final row.
- Signed overflow: ACC_BW=8 sweep, psum 100 over K=2 → output -56 (wrap).
- Extra psum (ROWS+1 in one tile) → seq_err=1, sums unaffected. cfg_k_tiles=0 on start → cfg_err=1, ready stays 1.
- rst asserted mid-STREAM → next cycle ready=1, all strobes 0; a fresh job then completes correctly.

Source files
------------

// File: rtl/tile_scheduler_pkg.sv
// Shared types and defaults for the multi-tile scheduler and its accumulator buffer.
package tile_scheduler_pkg;

  localparam int ACC_BITWIDTH = 32;
  localparam int DEF_COLS     = 4;
  localparam int DEF_P_BW     = 16;
  localparam int DEF_ROWS     = 16;
  localparam int DEF_MAX_K    = 16;
  localparam int DEF_MAX_N    = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN,
    FLUSH
  } sched_state_t;

  // Address width for a row index; a single-row buffer still needs one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tile_scheduler_psum_acc_buffer.sv
// ROWS x COLS accumulator storage: per-lane write with first/accumulate select,
// registered read port that holds its value while rd_en is low.
module psum_acc_buffer
  import tile_scheduler_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int P_BW   = DEF_P_BW,
  parameter int ACC_BW = ACC_BITWIDTH,
  parameter int ROWS   = DEF_ROWS,
  parameter int AW     = addr_width(ROWS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_first,
  input  logic [AW-1:0]                wr_addr,
  input  logic [COLS-1:0][P_BW-1:0]    wr_psum,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  output logic [COLS-1:0][ACC_BW-1:0]  rd_data
);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
    logic [ACC_BW-1:0]        mem_q [ROWS];
    logic [ACC_BW-1:0]        rd_q;
    logic signed [P_BW-1:0]   psum_lane;
    logic signed [ACC_BW-1:0] psum_ext;

    assign psum_lane = wr_psum[gi];
    assign psum_ext  = ACC_BW'(psum_lane);

    // First K tile overwrites the row; later tiles add, wrapping at ACC_BW bits.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_first ? psum_ext : (mem_q[wr_addr] + psum_ext);
      end
    end

    // Registered read; the output only moves when a new row is requested.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else if (rd_en) begin
        rd_q <= mem_q[rd_addr];
      end
    end

    assign rd_data[gi] = rd_q;
  end

endmodule

// File: rtl/tile_scheduler.sv
// Sequences N output tiles x K input-channel tiles through the datapath,
// accumulates partial sums and streams finished rows out on a valid/ready port.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int P_BW   = DEF_P_BW,
  parameter int ACC_BW = ACC_BITWIDTH,
  parameter int ROWS   = DEF_ROWS,
  parameter int MAX_K  = DEF_MAX_K,
  parameter int MAX_N  = DEF_MAX_N,
  localparam int KW    = $clog2(MAX_K + 1),
  localparam int NW    = $clog2(MAX_N + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KW-1:0]                cfg_k_tiles,
  input  logic [NW-1:0]                cfg_n_tiles,
  output logic                         ready,
  output logic                         cfg_err,
  output logic                         seq_err,
  output logic                         w_read,
  output logic                         if_read,
  output logic                         clr_w,
  output logic                         clr_if,
  output logic                         switch,
  input  logic                         w_done,
  input  logic                         if_done,
  input  logic                         psum_valid,
  input  logic [COLS-1:0][P_BW-1:0]    psum_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS-1:0][ACC_BW-1:0]  out_data,
  output logic                         out_last
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int AW = addr_width(ROWS);

  sched_state_t  state_q, state_d;
  logic [KW-1:0] k_tiles_q, k_q;
  logic [NW-1:0] n_tiles_q, n_q;
  logic [RW-1:0] row_cnt_q;
  logic [AW-1:0] rd_row_q;
  logic          pf_active_q, out_valid_q;
  logic          clr_w_q, clr_if_q, switch_q, cfg_err_q, seq_err_q;

  logic last_k, last_n, last_row, rows_full, cfg_ok, xfer;
  logic enter_stream, more_tiles, psum_in_tile, drain_to_flush;
  logic rd_en;
  logic [AW-1:0] rd_addr;

  assign last_k         = (k_q == k_tiles_q - KW'(1));
  assign last_n         = (n_q == n_tiles_q - NW'(1));
  assign last_row       = (rd_row_q == AW'(ROWS - 1));
  assign rows_full      = (row_cnt_q == RW'(ROWS));
  assign cfg_ok         = (cfg_k_tiles != '0) && (cfg_n_tiles != '0);
  assign xfer           = out_valid_q && out_ready;
  assign enter_stream   = (state_d == STREAM) && (state_q != STREAM);
  assign more_tiles     = !(last_k && last_n);
  assign psum_in_tile   = psum_valid && ((state_q == STREAM) || (state_q == DRAIN));
  assign drain_to_flush = (state_q == DRAIN) && (state_d == FLUSH);

  // Next-state logic: n outer loop, k inner loop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && cfg_ok) state_d = LOAD_W;
      LOAD_W:  if (w_done) state_d = SWITCH;
      SWITCH:  state_d = STREAM;
      STREAM:  if (if_done) state_d = DRAIN;
      DRAIN:   if (rows_full && !pf_active_q) state_d = last_k ? FLUSH : SWITCH;
      FLUSH:   if (xfer && last_row) state_d = last_n ? IDLE : SWITCH;
      default: state_d = IDLE;
    endcase
  end

  // State register, entry-registered strobes and the weight prefetch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_w_q     <= 1'b0;
      clr_if_q    <= 1'b0;
      switch_q    <= 1'b0;
      pf_active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_w_q  <= ((state_d == LOAD_W) && (state_q != LOAD_W)) || (enter_stream && more_tiles);
      clr_if_q <= enter_stream;
      switch_q <= (state_d == SWITCH) && (state_q != SWITCH);
      // Prefetch of the next tile's weights starts with the current tile's stream.
      if (enter_stream && more_tiles) begin
        pf_active_q <= 1'b1;
      end else if (w_done) begin
        pf_active_q <= 1'b0;
      end
    end
  end

  // Job config, tile/row counters, sticky flags and the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_tiles_q   <= '0;
      n_tiles_q   <= '0;
      k_q         <= '0;
      n_q         <= '0;
      row_cnt_q   <= '0;
      rd_row_q    <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        if (cfg_ok) begin
          k_tiles_q <= cfg_k_tiles;
          n_tiles_q <= cfg_n_tiles;
          k_q       <= '0;
          n_q       <= '0;
          cfg_err_q <= 1'b0;
          seq_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (enter_stream) begin
        row_cnt_q <= '0;
      end else if (psum_in_tile && !rows_full) begin
        row_cnt_q <= row_cnt_q + RW'(1);
      end
      // A row beyond the tile height is dropped but flagged.
      if (psum_in_tile && rows_full) begin
        seq_err_q <= 1'b1;
      end
      if ((state_q == DRAIN) && (state_d == SWITCH)) begin
        k_q <= k_q + KW'(1);
      end
      if ((state_q == FLUSH) && (state_d == SWITCH)) begin
        n_q <= n_q + NW'(1);
        k_q <= '0;
      end
      if (drain_to_flush) begin
        out_valid_q <= 1'b1;
        rd_row_q    <= '0;
      end else if ((state_q == FLUSH) && xfer) begin
        if (last_row) begin
          out_valid_q <= 1'b0;
        end else begin
          rd_row_q <= rd_row_q + AW'(1);
        end
      end
    end
  end

  // Row 0 is fetched as DRAIN exits; each handshake fetches the following row.
  assign rd_en   = drain_to_flush || ((state_q == FLUSH) && xfer && !last_row);
  assign rd_addr = (state_q == FLUSH) ? (rd_row_q + AW'(1)) : '0;

  psum_acc_buffer #(
    .COLS   (COLS),
    .P_BW   (P_BW),
    .ACC_BW (ACC_BW),
    .ROWS   (ROWS),
    .AW     (AW)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (psum_in_tile && !rows_full),
    .wr_first (k_q == '0),
    .wr_addr  (row_cnt_q[AW-1:0]),
    .wr_psum  (psum_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (out_data)
  );

  assign ready     = (state_q == IDLE);
  assign cfg_err   = cfg_err_q;
  assign seq_err   = seq_err_q;
  assign w_read    = (state_q == LOAD_W) || pf_active_q;
  assign if_read   = (state_q == STREAM);
  assign clr_w     = clr_w_q;
  assign clr_if    = clr_if_q;
  assign switch    = switch_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && last_row && last_n;

endmodule
